// File: rtl/led_lights_pkg.sv
// led_lights_pkg: shared types and helpers for the LED/seven-segment countdown blocks
package led_lights_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
        return (nibble > BCD_NINE) ? BCD_NINE : nibble;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider issuing one tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;

    assign tick = enable && (pre == LAST);

    // phase counter: clear wins, otherwise advance only while enabled and wrap on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (clear)
            pre <= '0;
        else if (enable)
            pre <= tick ? '0 : pre + 1'b1;
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: BCD countdown with pause/resume/abort; COUNTDOWN_AUTO_RELOAD_EN adds periodic reload
module countdown_timer_ctrl
    import led_lights_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS*4-1:0] load_bcd,
    input  logic                start,
    input  logic                pause,
    input  logic                abort,
    output logic [DIGITS*4-1:0] bcd_out,
    output logic                disp_valid,
    output logic                busy,
    output logic                paused,
    output logic                done
);

    localparam int W = DIGITS * 4;

    state_t         state, state_nx;
    logic [W-1:0]   count, count_nx, load_sat, count_dec;
    logic           load_go, clear, enable, tick;

    for (genvar i = 0; i < DIGITS; i++) begin : g_sat
        assign load_sat[i*4 +: 4] = bcd_sat(load_bcd[i*4 +: 4]);
    end

    // start in IDLE only counts when no higher-priority abort/pause is present
    assign load_go = (state == IDLE) && start && !abort && !pause;
    assign clear   = load_go || (abort && state != IDLE);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0] reload;

    // the DONE cycle doubles as the first prescaler cycle of the next period
    assign enable = ((state == RUN) && !abort && !pause) ||
                    ((state == DONE) && !abort && reload != '0);

    // keeps the sanitised start value for periodic reloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            reload <= '0;
        else if (load_go)
            reload <= load_sat;
    end
`else
    assign enable = (state == RUN) && !abort && !pause;
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (enable),
        .tick   (tick)
    );

    // BCD decrement: a zero digit becomes nine and passes the borrow upward
    always_comb begin
        logic borrow;
        count_dec = count;
        borrow    = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            count_dec[d*4 +: 4] = borrow ? ((count[d*4 +: 4] == 4'd0) ? BCD_NINE : count[d*4 +: 4] - 4'd1)
                                         : count[d*4 +: 4];
            borrow = borrow && (count[d*4 +: 4] == 4'd0);
        end
    end

    // next state and count, with abort > pause > start > tick in every state
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE: begin
                if (load_go) begin
                    count_nx = load_sat;
                    state_nx = (load_sat == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (!pause && tick && count != '0) begin
                    count_nx = count_dec;
                    state_nx = (count == W'(1)) ? DONE : RUN;
                end else if (pause) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (start) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                state_nx = (!abort && reload != '0) ? RUN : IDLE;
                count_nx = (!abort && reload != '0) ? reload : '0;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, count and status flags all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            disp_valid <= 1'b0;
            busy       <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            disp_valid <= state_nx != IDLE;
            busy       <= (state_nx == RUN) || (state_nx == PAUSE);
            paused     <= state_nx == PAUSE;
            done       <= state_nx == DONE;
        end
    end

    assign bcd_out = count;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed and random stimulus against a decimal-arithmetic reference model
module tb_countdown_timer_ctrl;

    localparam int DIGITS = 4;
    localparam int TD     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [15:0] load_bcd = '0;
    logic [15:0] bcd_out;
    logic        disp_valid, busy, paused, done;

    int checks = 0, errors = 0;

    int m_cnt, m_el, m_rel, m_dones;
    bit m_run, m_pz, m_dn;

    always #5 clk = ~clk;

    countdown_timer_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_bcd   (load_bcd),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .bcd_out    (bcd_out),
        .disp_valid (disp_valid),
        .busy       (busy),
        .paused     (paused),
        .done       (done)
    );

    function automatic int sat_val(input logic [15:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            int n = int'(v[i*4 +: 4]);
            r = r * 10 + (n > 9 ? 9 : n);
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_el = 0; m_rel = 0;
        m_run = 0; m_pz = 0; m_dn = 0;
    endtask

    task automatic model_step(input bit st, input bit pa, input bit ab, input logic [15:0] ld);
        if (m_dn) begin
            m_dn = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (!ab && m_rel > 0) begin
                m_run = 1; m_cnt = m_rel; m_el = 1;
            end
`endif
        end else if (m_run) begin
            if (ab) begin
                m_run = 0; m_cnt = 0; m_el = 0;
            end else if (pa) begin
                m_run = 0; m_pz = 1;
            end else begin
                m_el++;
                if (m_el == TD) begin
                    m_el = 0;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_run = 0; m_dn = 1; m_dones++;
                    end
                end
            end
        end else if (m_pz) begin
            if (ab) begin
                m_pz = 0; m_cnt = 0; m_el = 0;
            end else if (st) begin
                m_pz = 0; m_run = 1;
            end
        end else if (st && !ab && !pa) begin
            m_rel = sat_val(ld);
            m_el  = 0;
            m_cnt = m_rel;
            if (m_rel == 0) begin
                m_dn = 1; m_dones++;
            end else
                m_run = 1;
        end
    endtask

    task automatic compare_all();
        check("bcd_out", 32'(bcd_out), 32'(to_bcd(m_cnt)));
        check("disp_valid", 32'(disp_valid), 32'(m_run | m_pz | m_dn));
        check("busy", 32'(busy), 32'(m_run | m_pz));
        check("paused", 32'(paused), 32'(m_pz));
        check("done", 32'(done), 32'(m_dn));
    endtask

    task automatic cyc(input bit st, input bit pa, input bit ab, input logic [15:0] ld);
        start = st; pause = pa; abort = ab; load_bcd = ld;
        @(posedge clk);
        model_step(st, pa, ab, ld);
        #1;
        compare_all();
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, load_bcd);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_bcd", 32'(bcd_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_disp", 32'(disp_valid), 0);
        check("rst_done", 32'(done), 0);
        compare_all();
        #1;
        rst_n = 1;
    endtask

    initial begin
        int d0, last, idx;
        model_reset();
        m_dones = 0;
        #12;
        compare_all();
        check("reset_paused", 32'(paused), 0);
        rst_n = 1;

        cyc(1, 0, 0, 16'h0012);
        idle(3);
        check("first_hold", 32'(bcd_out), 32'h0012);
        idle(1);
        check("first_step", 32'(bcd_out), 32'h0011);
        d0 = m_dones;
        for (int i = 0; i < 100 && (m_run || m_dn); i++) idle(1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        check("done_once", 32'(m_dones - d0), 1);
        check("end_busy", 32'(busy), 0);
`endif
        cyc(0, 0, 1, 16'h0);

        cyc(1, 0, 0, 16'h1000);
        idle(4);
        check("borrow", 32'(bcd_out), 32'h0999);
        cyc(0, 0, 1, 16'h0);

        cyc(1, 0, 0, 16'h0A5F);
        check("sanitise", 32'(bcd_out), 32'h0959);
        cyc(0, 0, 1, 16'h0);

        cyc(1, 0, 0, 16'h0007);
        idle(2);
        cyc(0, 1, 0, 16'h0007);
        idle(20);
        check("pause_hold", 32'(bcd_out), 32'h0007);
        check("pause_flag", 32'(paused), 1);
        cyc(1, 0, 0, 16'h0007);
        idle(1);
        check("resume_hold", 32'(bcd_out), 32'h0007);
        idle(1);
        check("resume_step", 32'(bcd_out), 32'h0006);
        cyc(0, 0, 1, 16'h0);

        cyc(1, 0, 0, 16'h0005);
        idle(3);
        cyc(0, 1, 1, 16'h0005);
        check("abort_bcd", 32'(bcd_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);

        cyc(1, 0, 0, 16'h0000);
        check("zero_done", 32'(done), 1);
        check("zero_disp", 32'(disp_valid), 1);
        check("zero_busy", 32'(busy), 0);
        idle(1);
        check("zero_disp_off", 32'(disp_valid), 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        cyc(1, 0, 0, 16'h0002);
        last = -1;
        for (idx = 0; idx < 40; idx++) begin
            idle(1);
            if (done) begin
                if (last >= 0) check("ar_period", 32'(idx - last), 8);
                last = idx;
            end
        end
        for (int i = 0; i < 20 && !done; i++) idle(1);
        check("ar_in_done", 32'(done), 1);
        cyc(0, 0, 1, 16'h0);
        check("ar_abort_busy", 32'(busy), 0);
        check("ar_abort_disp", 32'(disp_valid), 0);
`endif

        cyc(1, 0, 0, 16'h0042);
        idle(2);
        do_reset();
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ld;
            ld = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                             : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)};
            if ($urandom_range(0, 499) == 0)
                do_reset();
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 29) == 0, ld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Parametrised BCD countdown engine for the LED/seven-segment subsystem. It generalises the single-shot fixed-width countdown:
- configurable digit count and tick period
- pause/resume and abort controls
- done pulse plus level status
- count held natively in BCD digits, so no binary-to-BCD converter is needed downstream

It feeds the existing seg7 display driver directly through bcd_out and disp_valid.

Parameters:
DIGITS, 4, number of BCD digits held and counted (1..8)
TICK_DIV, 25_000_000, clk cycles per count decrement (>=2)
PRE_W, $clog2(TICK_DIV), prescaler width (derived localparam, not overridable)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
load_bcd  input  DIGITS*4  start value, digit 0 = LSB nibble; sampled on start from IDLE
start  input  1  in IDLE: load and run; in PAUSE: resume
pause  input  1  in RUN: freeze count and prescaler
abort  input  1  any non-IDLE state: return to IDLE, count cleared
bcd_out  output  DIGITS*4  current count, BCD
disp_valid  output  1  high in RUN, PAUSE and DONE
busy  output  1  high in RUN or PAUSE
paused  output  1  high in PAUSE
done  output  1  one-cycle pulse when count reaches zero

Behaviour:
- Reset: state IDLE; bcd_out, prescaler, disp_valid, busy, paused, done all 0.
- Reset mid-operation returns immediately to this reset state.
- States are IDLE, RUN, PAUSE, DONE. All outputs are registered and reflect the current state.
- Event priority in every state: abort > pause > start > tick.
- IDLE:
  - start with a nonzero load value: load the count, clear the prescaler, go to RUN next cycle.
  - start with an all-zero load value: go to DONE directly.
  - Load sanitising: any nibble > 9 is loaded as 9.
  - Count holds its last value. It is 0 after reset, abort or DONE.
- RUN:
  - The prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and issues an internal tick.
  - On tick: BCD decrement. Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - If the tick takes the count from 1 to 0, go to DONE.
  - First decrement occurs exactly TICK_DIV cycles after entering RUN.
  - pause: go to PAUSE. The prescaler value is retained, and a tick coinciding with pause is discarded.
  - abort: go to IDLE, count = 0.
- PAUSE:
  - Count and prescaler are frozen.
  - start: go to RUN, resuming from the retained prescaler phase.
  - abort: go to IDLE.
  - pause is ignored.
- DONE: lasts exactly one cycle; done = 1 and bcd_out = 0, then IDLE. abort in DONE has no additional effect.
- start while busy is ignored, except resume from PAUSE.
- Count never wraps below 0. Decrement is only performed when the count is nonzero.

Optional Feature:
COUNTDOWN_AUTO_RELOAD_EN
- Defined:
  - The sanitised start value is kept in a reload register.
  - DONE goes to RUN, reloading the count and clearing the prescaler, instead of IDLE. This gives a periodic timer with done every N·TICK_DIV cycles after the first period.
  - abort, including abort asserted during DONE, returns to IDLE.
  - A zero load value does not auto-reload; it goes to IDLE.
- Undefined: no reload register; behaviour exactly as above.

Decomposition:
- Package led_lights_pkg holds:
  - the state enum typedef (IDLE/RUN/PAUSE/DONE)
  - localparam BCD_NINE = 4'd9
  - a function bcd_sat(nibble) for load sanitising
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst_n, clear, enable, tick). Its clear and enable are driven from the FSM. It replaces the ad-hoc divider for this block.

Test Plan:
- TICK_DIV=4, DIGITS=4, load 0x0012, start pulse:
  - bcd_out steps 0012→0011→…→0000, each step 4 cycles apart, first step 4 cycles after RUN entry.
  - done pulses once as the count reaches 0000; busy falls with done.
- Borrow chain, load 0x1000: after one tick bcd_out = 0x0999. Load 0x0A5F: bcd_out shows 0x0959 after load.
- Pause at prescaler = 2 with count 0x0007:
  - count holds 0x0007 for 20 cycles, paused = 1.
  - start resumes, and the next decrement occurs 2 cycles later.
- abort asserted together with pause and a tick in RUN: next state IDLE, bcd_out = 0, no done.
- Load 0x0000 with start: done pulse one cycle later, disp_valid for 1 cycle, never busy.
- COUNTDOWN_AUTO_RELOAD_EN, load 0x0002, TICK_DIV=4:
  - done every 8 cycles, bcd_out cycling 2,1,0→2.
  - abort during DONE ends in IDLE.
- Bonus: async rst_n asserted mid-RUN clears all outputs within the same cycle.
